// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter.
package rr_arbiter_pkg;

    // Arbiter FSM: IDLE means no grant is held, BUSY means one requester owns the resource.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Hold counter width, wide enough for the largest HOLD_MAX (255).
    localparam int HOLD_W = 8;

endpackage : rr_arbiter_pkg

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Optional feature macro: RR_ARB_LOCK_EN adds the lock_i signal.
interface rr_arbiter_if #(
    parameter int REQ_NUM = 8
) ();
    logic [REQ_NUM-1:0]         req_i;
    logic                       done_i;
`ifdef RR_ARB_LOCK_EN
    logic                       lock_i;
`endif
    logic [REQ_NUM-1:0]         gnt_o;
    logic [$clog2(REQ_NUM)-1:0] gnt_id_o;
    logic                       busy_o;
    logic                       timeout_o;

    // Requester/resource side: drives requests and completion, observes grants.
    modport master (
        output req_i,
        output done_i,
`ifdef RR_ARB_LOCK_EN
        output lock_i,
`endif
        input  gnt_o,
        input  gnt_id_o,
        input  busy_o,
        input  timeout_o
    );

    // Arbiter side.
    modport slave (
        input  req_i,
        input  done_i,
`ifdef RR_ARB_LOCK_EN
        input  lock_i,
`endif
        output gnt_o,
        output gnt_id_o,
        output busy_o,
        output timeout_o
    );
endinterface : rr_arbiter_if

// File: rtl/rr_lsb_pick.sv
// Lowest-set-bit isolation plus one-hot to binary index encode (combinational).
module rr_lsb_pick #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(WIDTH);

    // Two's-complement trick keeps only the lowest set bit.
    assign onehot = vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});
    assign any    = |vec;

    // Encode the isolated bit into its binary position.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end
endmodule : rr_lsb_pick

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold timeout and
// optional grant lock (macro RR_ARB_LOCK_EN adds lock_i to the bus).
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int REQ_NUM  = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic         clk_i,
    input  logic         srst_i,
    rr_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(REQ_NUM);

    state_t              state_r, state_nxt_s;
    logic [REQ_NUM-1:0]  req_s, req_masked_s, mask_r, mask_nxt_s, mask_grant_s;
    logic [REQ_NUM-1:0]  gnt_r, gnt_nxt_s, pick_m_oh_s, pick_u_oh_s, win_oh_s;
    logic [ID_W-1:0]     gnt_id_r, gnt_id_nxt_s, pick_m_id_s, pick_u_id_s, win_id_s;
    logic                pick_m_any_s, pick_u_any_s;
    logic                busy_r, busy_nxt_s, timeout_r, timeout_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
    logic                done_s, lock_s, norm_rel_s, lock_hold_s, hold_exp_s;

    assign req_s  = bus.req_i;
    assign done_s = bus.done_i;
`ifdef RR_ARB_LOCK_EN
    assign lock_s = bus.lock_i;
`else
    assign lock_s = 1'b0;
`endif

    // Masked pick continues the rotation; unmasked pick handles the wrap.
    assign req_masked_s = req_s & mask_r;

    rr_lsb_pick #(.WIDTH(REQ_NUM)) u_pick_masked (
        .vec    (req_masked_s),
        .onehot (pick_m_oh_s),
        .idx    (pick_m_id_s),
        .any    (pick_m_any_s)
    );

    rr_lsb_pick #(.WIDTH(REQ_NUM)) u_pick_unmasked (
        .vec    (req_s),
        .onehot (pick_u_oh_s),
        .idx    (pick_u_id_s),
        .any    (pick_u_any_s)
    );

    assign win_oh_s = pick_m_any_s ? pick_m_oh_s : pick_u_oh_s;
    assign win_id_s = pick_m_any_s ? pick_m_id_s : pick_u_id_s;

    // Release on done (unless locked) or when the owner drops its request;
    // a normal release always takes precedence over the timeout.
    assign norm_rel_s  = (done_s & ~lock_s) | ((req_s & gnt_r) == {REQ_NUM{1'b0}});
    assign lock_hold_s = done_s & lock_s;
    assign hold_exp_s  = (hold_cnt_r == HOLD_W'(HOLD_MAX - 1));

    // Post-grant mask: priority starts just above the winner, all ones after the top index.
    always_comb begin
        mask_grant_s = {REQ_NUM{1'b0}};
        for (int b = 0; b < REQ_NUM; b++) begin
            if ((b > int'(win_id_s)) || (win_id_s == ID_W'(REQ_NUM - 1))) begin
                mask_grant_s[b] = 1'b1;
            end else begin
                mask_grant_s[b] = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s != {REQ_NUM{1'b0}}) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (norm_rel_s || hold_exp_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: next values of the registered outputs, counter and mask.
    always_comb begin
        gnt_nxt_s      = {REQ_NUM{1'b0}};
        gnt_id_nxt_s   = {ID_W{1'b0}};
        busy_nxt_s     = 1'b0;
        timeout_nxt_s  = 1'b0;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
        mask_nxt_s     = mask_r;
        case (state_r)
            IDLE: begin
                if (req_s != {REQ_NUM{1'b0}}) begin
                    gnt_nxt_s    = win_oh_s;
                    gnt_id_nxt_s = win_id_s;
                    busy_nxt_s   = 1'b1;
                    mask_nxt_s   = mask_grant_s;
                end else begin
                    mask_nxt_s   = mask_r;
                end
            end
            BUSY: begin
                if (norm_rel_s) begin
                    timeout_nxt_s = 1'b0;
                end else if (hold_exp_s) begin
                    timeout_nxt_s = 1'b1;
                end else begin
                    gnt_nxt_s      = gnt_r;
                    gnt_id_nxt_s   = gnt_id_r;
                    busy_nxt_s     = 1'b1;
                    hold_cnt_nxt_s = lock_hold_s ? {HOLD_W{1'b0}} : (hold_cnt_r + HOLD_W'(1));
                end
            end
            default: mask_nxt_s = mask_r;
        endcase
    end

    // Datapath registers; reset drops any grant and restores requester 0 priority.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            gnt_r      <= {REQ_NUM{1'b0}};
            gnt_id_r   <= {ID_W{1'b0}};
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            mask_r     <= {REQ_NUM{1'b1}};
        end else begin
            gnt_r      <= gnt_nxt_s;
            gnt_id_r   <= gnt_id_nxt_s;
            busy_r     <= busy_nxt_s;
            timeout_r  <= timeout_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            mask_r     <= mask_nxt_s;
        end
    end

    assign bus.gnt_o     = gnt_r;
    assign bus.gnt_id_o  = gnt_id_r;
    assign bus.busy_o    = busy_r;
    assign bus.timeout_o = timeout_r;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (REQ_NUM=4, HOLD_MAX=4): directed
// scenarios with literal expectations plus random traffic against a model.
module tb_rr_arbiter;
    localparam int N  = 4;
    localparam int HM = 4;

    logic         clk = 1'b0;
    logic         srst;
    logic [N-1:0] req;
    logic         done;
    logic         lock;
    logic         chk_en;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_if #(.REQ_NUM(N)) bus ();
    assign bus.req_i  = req;
    assign bus.done_i = done;
`ifdef RR_ARB_LOCK_EN
    assign bus.lock_i = lock;
`endif

    rr_arbiter #(.REQ_NUM(N), .HOLD_MAX(HM)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner, cycles held, rotation start point, timeout flag.
    logic m_busy;
    int   m_id;
    int   m_start;
    int   m_held;
    logic m_to;

    // Search upward from start, then fall back to the lowest requester overall.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = start; i < N; i++) if (r[i]) return i;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge srst) begin
        if (!srst) begin
            m_busy  <= 1'b0;
            m_id    <= 0;
            m_start <= 0;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (req != 0) begin
                    m_busy  <= 1'b1;
                    m_id    <= pick(req, m_start);
                    m_start <= (pick(req, m_start) + 1) % N;
                    m_held  <= 1;
                end
            end else if ((done && !lock) || !req[m_id]) begin
                m_busy <= 1'b0;
            end else if (m_held == HM) begin
                m_busy <= 1'b0;
                m_to   <= 1'b1;
            end else if (done && lock) begin
                m_held <= 1;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt",  32'(bus.gnt_o),     m_busy ? (32'd1 << m_id) : 32'd0);
            check("model_id",   32'(bus.gnt_id_o),  m_busy ? 32'(m_id) : 32'd0);
            check("model_busy", 32'(bus.busy_o),    32'(m_busy));
            check("model_to",   32'(bus.timeout_o), 32'(m_to));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_rr [5];

    initial begin
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        srst = 1'b0; req = '0; done = 1'b0; lock = 1'b0; chk_en = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_gnt",  32'(bus.gnt_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_id",   32'(bus.gnt_id_o), 32'd0);
        check("rst_to",   32'(bus.timeout_o), 32'd0);
        srst = 1'b1;

        // All requesting: rotation 0,1,2,3,0 with an idle cycle between grants.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_order", 32'(bus.gnt_o), 32'(exp_rr[k]));
            done = 1'b1;
            step();
            check("rr_gap", 32'(bus.busy_o), 32'd0);
            done = 1'b0;
        end
        req = 4'b0000;

        // Single request to 2, then held past HOLD_MAX -> timeout, wrap to 0.
        step();
        req = 4'b0100;
        step();
        check("single_gnt",  32'(bus.gnt_o), 32'h4);
        check("single_id",   32'(bus.gnt_id_o), 32'd2);
        check("single_busy", 32'(bus.busy_o), 32'd1);
        req = 4'b0101;
        repeat (3) begin
            step();
            check("hold_gnt", 32'(bus.gnt_o), 32'h4);
        end
        step();
        check("to_busy",  32'(bus.busy_o), 32'd0);
        check("to_pulse", 32'(bus.timeout_o), 32'd1);
        step();
        check("wrap_gnt",   32'(bus.gnt_o), 32'h1);
        check("to_cleared", 32'(bus.timeout_o), 32'd0);
        done = 1'b1;
        step();
        check("done_rel", 32'(bus.busy_o), 32'd0);
        done = 1'b0;

        // done coinciding with the timeout edge is a normal release.
        req = 4'b0010;
        step();
        check("coin_gnt", 32'(bus.gnt_o), 32'h2);
        repeat (3) step();
        done = 1'b1;
        step();
        check("coin_busy", 32'(bus.busy_o), 32'd0);
        check("coin_to",   32'(bus.timeout_o), 32'd0);
        done = 1'b0;

        // Reset mid-grant clears outputs at once and restores requester 0 priority.
        step();
        check("pre_rst_gnt", 32'(bus.gnt_o), 32'h2);
        srst = 1'b0;
        #1;
        check("async_gnt",  32'(bus.gnt_o), 32'd0);
        check("async_id",   32'(bus.gnt_id_o), 32'd0);
        check("async_busy", 32'(bus.busy_o), 32'd0);
        check("async_to",   32'(bus.timeout_o), 32'd0);
        step();
        srst = 1'b1;
        req  = 4'b1010;
        step();
        check("post_rst_gnt", 32'(bus.gnt_o), 32'h2);
        check("post_rst_id",  32'(bus.gnt_id_o), 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        step();

`ifdef RR_ARB_LOCK_EN
        // Lock keeps the grant through done; dropping lock releases.
        req = 4'b1000;
        step();
        check("lock_gnt0", 32'(bus.gnt_o), 32'h8);
        done = 1'b1;
        lock = 1'b1;
        repeat (2) begin
            step();
            check("lock_keep", 32'(bus.gnt_o), 32'h8);
        end
        lock = 1'b0;
        step();
        check("lock_rel", 32'(bus.busy_o), 32'd0);
        done = 1'b0;
        req  = 4'b0000;
        step();
`endif

        // Random traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom_range(15));
            done = ($urandom_range(2) == 0);
`ifdef RR_ARB_LOCK_EN
            lock = ($urandom_range(1) == 0);
`endif
            srst = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        srst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_rr_arbiter

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 8: number of requesters sharing the resource, range 2..32.
REQ-002 Parameter HOLD_MAX, default 16: maximum cycles one grant may be held before forced release, range 2..255.
REQ-003 clk_i  input  1  clock, all state updates on its rising edge.
REQ-004 srst_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  REQ_NUM  per-requester request, held high until served.
REQ-006 done_i  input  1  resource signals end of the current transaction.
REQ-007 lock_i  input  1  granted requester keeps the grant past done_i (present only with RR_ARB_LOCK_EN).
REQ-008 gnt_o  output  REQ_NUM  registered one-hot grant, all zero when idle.
REQ-009 gnt_id_o  output  $clog2(REQ_NUM)  binary index of the granted requester, 0 when idle.
REQ-010 busy_o  output  1  high while a grant is held.
REQ-011 timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have two states: IDLE (no grant) and BUSY (grant held).
REQ-013 In IDLE with req_i != 0 at edge k, the arbiter SHALL enter BUSY and drive gnt_o, gnt_id_o and busy_o from edge k+1; in IDLE with req_i == 0 it SHALL stay idle.
REQ-014 The winner SHALL be the lowest set bit of (req_i & mask), isolated as x & (~x + 1); if that term is zero, the lowest set bit of req_i SHALL win.
REQ-015 On each grant to index i, mask SHALL become ones in bits i+1..REQ_NUM-1; after a grant to REQ_NUM-1, mask SHALL become all ones (wrap-around).
REQ-016 In BUSY, done_i high, or req_i[gnt_id_o] low, SHALL return the FSM to IDLE and clear gnt_o, gnt_id_o and busy_o at the next edge.
REQ-017 After any release, one IDLE cycle SHALL separate it from the next grant.
REQ-018 A hold counter SHALL clear on grant and increment each BUSY cycle; when it reaches HOLD_MAX-1 without a release, the next edge SHALL release the grant and pulse timeout_o for exactly one cycle.
REQ-019 If done_i and timeout coincide, the release SHALL be treated as normal and timeout_o SHALL stay low.
REQ-020 gnt_o SHALL never have more than one bit set, and SHALL only set a bit whose req_i was high at the arbitration edge.
REQ-021 Changes on req_i of non-granted requesters during BUSY SHALL have no effect until the next IDLE cycle.

Reset
REQ-022 Asserting srst_i low SHALL immediately force the state to IDLE; clear gnt_o, gnt_id_o, busy_o, timeout_o and the hold counter; and set mask to all ones, so requester 0 has highest priority.
REQ-023 Reset asserted mid-grant SHALL drop the grant with no timeout pulse and no pointer update.

Configuration
REQ-024 With RR_ARB_LOCK_EN defined, port lock_i SHALL exist; done_i with lock_i high SHALL keep the grant, restart the hold counter and leave mask unchanged; a timeout SHALL still release.
REQ-025 Without RR_ARB_LOCK_EN, port lock_i SHALL be absent and behaviour SHALL equal lock_i tied low.

Structure
REQ-026 Package rr_arbiter_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the HOLD_MAX counter width constant.
REQ-027 Sub-module rr_lsb_pick SHALL implement the combinational lowest-set-bit isolation plus one-hot-to-index encode; it SHALL be instantiated twice (masked and unmasked).

Verification (REQ_NUM=4, HOLD_MAX=4)
REQ-028 Reset, then req_i=4'b1111 held with done_i pulsed each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-029 req_i=4'b0100 at edge 0 -> gnt_o=4'b0100, gnt_id_o=2, busy_o=1 at edge 1.
REQ-030 Grant to 2, done_i held low for 4 cycles -> release plus timeout_o=1 for one cycle; with req_i=4'b0101 next grant goes to 0 (wrap).
REQ-031 Grant to 1, srst_i low mid-grant -> all outputs 0 at once; after reset req_i=4'b1010 -> grant to 1 (requester 0 highest priority, lowest active index wins).
REQ-032 With RR_ARB_LOCK_EN, grant to 3, done_i and lock_i high -> gnt_o stays 4'b1000; lock_i low with done_i -> release.
REQ-033 done_i and timeout on the same edge -> release with timeout_o=0.
